// File: rtl/dreg_pipe_if.sv
// Bundled control/data signals of the valid-qualified delay pipe.
// Tap ports appear only when DREG_PIPE_TAP_EN is defined.
interface dreg_pipe_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic                           en;
    logic                           flush;
    logic [WIDTH-1:0]               x;
    logic                           x_vld;
    logic [WIDTH-1:0]               y;
    logic                           y_vld;
    logic [$clog2(DEPTH+1)-1:0]     occ;
`ifdef DREG_PIPE_TAP_EN
    logic [$clog2(DEPTH)-1:0]       tap_sel;
    logic [WIDTH-1:0]               tap_y;
    logic                           tap_vld;

    modport master (output en, flush, x, x_vld, tap_sel,
                    input  y, y_vld, occ, tap_y, tap_vld);
    modport slave  (input  en, flush, x, x_vld, tap_sel,
                    output y, y_vld, occ, tap_y, tap_vld);
`else
    modport master (output en, flush, x, x_vld,
                    input  y, y_vld, occ);
    modport slave  (input  en, flush, x, x_vld,
                    output y, y_vld, occ);
`endif
endinterface

// File: rtl/dreg_pipe.sv
// DEPTH-stage enable-gated delay pipe with per-stage valid bits and an occupancy count.
// Define DREG_PIPE_TAP_EN to add a combinational read tap on any stage.
module dreg_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr,
    dreg_pipe_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [OCC_W-1:0] occ_q;

    // NOTE: state registers use <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < DEPTH; s++) d[s] <= '0;
            v     <= '0;
            occ_q <= '0;
        end else if (bus.flush) begin
            // Data is left in place; only validity and the count are dropped.
            v     <= '0;
            occ_q <= '0;
        end else if (bus.en) begin
            d[0] <= bus.x;
            for (int s = 1; s < DEPTH; s++) d[s] <= d[s-1];
            v     <= {v[DEPTH-2:0], bus.x_vld};
            occ_q <= occ_q + OCC_W'(bus.x_vld) - OCC_W'(v[DEPTH-1]);
        end
    end

    assign bus.y     = d[DEPTH-1];
    assign bus.y_vld = v[DEPTH-1];
    assign bus.occ   = occ_q;

`ifdef DREG_PIPE_TAP_EN
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        bus.tap_y   = '0;
        bus.tap_vld = 1'b0;
        if (int'(bus.tap_sel) < DEPTH) begin
            bus.tap_y   = d[bus.tap_sel];
            bus.tap_vld = v[bus.tap_sel];
        end
    end
`endif
endmodule

// File: tb/tb_dreg_pipe.sv
// Directed and randomized checks of dreg_pipe at WIDTH=4, DEPTH=4.
// Tap checks run only when DREG_PIPE_TAP_EN is defined.
module tb_dreg_pipe;
    logic clk = 1'b0;
    logic clr;
    int   n_cmp = 0;
    int   n_err = 0;

    dreg_pipe_if #(.WIDTH(4), .DEPTH(4)) bus ();
    dreg_pipe #(.WIDTH(4), .DEPTH(4)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ey, input logic ev, input logic [2:0] eo);
        check({tag, "_y"},     32'(bus.y),     32'(ey));
        check({tag, "_y_vld"}, 32'(bus.y_vld), 32'(ev));
        check({tag, "_occ"},   32'(bus.occ),   32'(eo));
    endtask

    logic [3:0] md [4];
    logic [3:0] mv;
    logic       e, f, xv;
    logic [3:0] xx;

    initial begin
        clr = 1'b1; bus.en = 1'b0; bus.flush = 1'b0; bus.x = '0; bus.x_vld = 1'b0;
`ifdef DREG_PIPE_TAP_EN
        bus.tap_sel = '0;
`endif
        step(); step();
        check_out("reset", 4'd0, 1'b0, 3'd0);

        // Single word: captured, then visible four enabled edges later.
        clr = 1'b0; bus.en = 1'b1; bus.x = 4'd8; bus.x_vld = 1'b1;
        step();
        check_out("single_e1", 4'd0, 1'b0, 3'd1);
        bus.x = 4'd0; bus.x_vld = 1'b0;
        step(); check_out("single_e2", 4'd0, 1'b0, 3'd1);
        step(); check_out("single_e3", 4'd0, 1'b0, 3'd1);
        step(); check_out("single_e4", 4'd8, 1'b1, 3'd1);
        step(); check_out("single_e5", 4'd0, 1'b0, 3'd0);

        // Stream 1..5, then alternate en to show holding.
        for (int i = 1; i <= 5; i++) begin
            bus.x = 4'(i); bus.x_vld = 1'b1;
            step();
        end
        check_out("stream_full", 4'd2, 1'b1, 3'd4);
        bus.x = 4'd0; bus.x_vld = 1'b0;
        bus.en = 1'b0; step(); check_out("stream_hold2", 4'd2, 1'b1, 3'd4);
        bus.en = 1'b1; step(); check_out("stream_y3",    4'd3, 1'b1, 3'd3);
        bus.en = 1'b0; step(); check_out("stream_hold3", 4'd3, 1'b1, 3'd3);
        bus.en = 1'b1; step(); check_out("stream_y4",    4'd4, 1'b1, 3'd2);
        bus.en = 1'b0; step(); check_out("stream_hold4", 4'd4, 1'b1, 3'd2);
        bus.en = 1'b1; step(); check_out("stream_y5",    4'd5, 1'b1, 3'd1);
        step();                check_out("stream_drain", 4'd0, 1'b0, 3'd0);

        // Fill with a..d, then flush with en=1 and a valid 9 offered.
        for (int i = 10; i <= 13; i++) begin
            bus.x = 4'(i); bus.x_vld = 1'b1;
            step();
        end
        check_out("flush_pre", 4'd10, 1'b1, 3'd4);
        bus.flush = 1'b1; bus.x = 4'd9; bus.x_vld = 1'b1;
        step();
        check_out("flush_edge", 4'd10, 1'b0, 3'd0);
        bus.flush = 1'b0; bus.x = 4'd0; bus.x_vld = 1'b0;
        step(); check_out("flush_a1", 4'd11, 1'b0, 3'd0);
        step(); check_out("flush_a2", 4'd12, 1'b0, 3'd0);
        step(); check_out("flush_a3", 4'd13, 1'b0, 3'd0);
        step(); check_out("flush_a4", 4'd0,  1'b0, 3'd0);

        // Stream 1..3, clear mid-stream with en=1, then a fresh word.
        for (int i = 1; i <= 3; i++) begin
            bus.x = 4'(i); bus.x_vld = 1'b1;
            step();
        end
        check_out("clr_pre", 4'd0, 1'b0, 3'd3);
        clr = 1'b1; bus.x = 4'd7; bus.x_vld = 1'b1;
        step();
        check_out("clr_edge", 4'd0, 1'b0, 3'd0);
        clr = 1'b0; bus.x = 4'd6; bus.x_vld = 1'b1;
        step(); check_out("clr_post1", 4'd0, 1'b0, 3'd1);
        bus.x = 4'd0; bus.x_vld = 1'b0;
        step(); check_out("clr_post2", 4'd0, 1'b0, 3'd1);
        step(); check_out("clr_post3", 4'd0, 1'b0, 3'd1);
        step(); check_out("clr_post4", 4'd6, 1'b1, 3'd1);

        // Random en/flush/x_vld against a reference pipe.
        clr = 1'b1; step(); clr = 1'b0;
        for (int s = 0; s < 4; s++) md[s] = '0;
        mv = '0;
        for (int i = 0; i < 1000; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 11) == 0);
            xv = 1'($urandom_range(0, 1));
            xx = 4'($urandom_range(0, 15));
            bus.en = e; bus.flush = f; bus.x_vld = xv; bus.x = xx;
            step();
            if (f) begin
                mv = '0;
            end else if (e) begin
                md[3] = md[2]; md[2] = md[1]; md[1] = md[0]; md[0] = xx;
                mv = {mv[2:0], xv};
            end
            check("rand_y",     32'(bus.y),     32'(md[3]));
            check("rand_y_vld", 32'(bus.y_vld), 32'(mv[3]));
            check("rand_occ",   32'(bus.occ),   32'($countones(mv)));
        end
        bus.flush = 1'b0;

`ifdef DREG_PIPE_TAP_EN
        clr = 1'b1; step(); clr = 1'b0;
        bus.en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.x = 4'(i); bus.x_vld = 1'b1;
            step();
        end
        bus.en = 1'b0; bus.x_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.tap_sel = 2'(i);
            #1;
            check("tap_y",   32'(bus.tap_y),   32'(4 - i));
            check("tap_vld", 32'(bus.tap_vld), 32'd1);
            step();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
